// File: rtl/operand_result_buffer.sv
// Operand/result store between the controller and the PE/systolic engines, with a valid/ready result streamer.
// Optional macro OPRESBUF_DROP_CNT_EN adds drop_cnt_o, a saturating count of dropped result writes.
module operand_result_buffer #(
  parameter  int DATA_W    = 8,
  parameter  int IN_DIM    = 4,
  parameter  int FLT_DIM   = 3,
  parameter  int RES_CH    = 3,
  parameter  int RES_ELEMS = 4,
  localparam int CH_W      = (RES_CH > 1) ? $clog2(RES_CH) : 1,
  localparam int IDX_W     = (RES_ELEMS > 1) ? $clog2(RES_ELEMS) : 1,
  localparam int A_W       = IN_DIM * IN_DIM * DATA_W,
  localparam int B_W       = FLT_DIM * FLT_DIM * DATA_W,
  localparam int SLOT_W    = RES_ELEMS * DATA_W,
  localparam int RES_W     = RES_CH * SLOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_valid_i,
  input  logic [A_W-1:0]    a_flat_i,
  input  logic [B_W-1:0]    b_flat_i,
  output logic              done_capture,
  output logic [A_W-1:0]    a_flat_o,
  output logic [B_W-1:0]    b_flat_o,
  input  logic [RES_CH-1:0] res_valid_i,
  input  logic [SLOT_W-1:0] res_data_i,
  output logic [RES_W-1:0]  res_flat_o,
  output logic [RES_CH-1:0] res_full_o,
  input  logic              rd_start_i,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              rd_busy_o,
  output logic              err_o
`ifdef OPRESBUF_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt_o
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_ELEMS - 1);

  state_t              state_r, state_n;
  logic [CH_W-1:0]     ch_r, ch_n;
  logic [IDX_W-1:0]    idx_r, idx_n;
  logic [A_W-1:0]      a_r;
  logic [B_W-1:0]      b_r;
  logic                done_r;
  logic [RES_W-1:0]    res_r, res_n;
  logic [RES_CH-1:0]   full_r, full_n;
  logic                rd_valid_r, rd_valid_n;
  logic                rd_last_r, rd_last_n;
  logic [DATA_W-1:0]   rd_data_r, rd_data_n;
  logic                err_r, err_n;

  logic                wr_found_s;
  logic [CH_W-1:0]     wr_ch_s;
  logic [7:0]          pop_s;
  logic                stream_hit_s;
  logic                wr_en_s;
  logic                rd_ch_ok_s;
  logic                accept_s;

  // Write arbitration: lowest set strobe wins, count of all strobes for drop accounting
  always_comb begin
    wr_found_s = 1'b0;
    wr_ch_s    = {CH_W{1'b0}};
    pop_s      = 8'd0;
    for (int k = 0; k < RES_CH; k++) begin
      wr_ch_s    = (res_valid_i[k] && !wr_found_s) ? CH_W'(k) : wr_ch_s;
      wr_found_s = wr_found_s | res_valid_i[k];
      pop_s      = pop_s + 8'(res_valid_i[k]);
    end
    stream_hit_s = wr_found_s && (state_r == STREAM) && (wr_ch_s == ch_r);
    wr_en_s      = wr_found_s && !stream_hit_s;
    rd_ch_ok_s   = ({1'b0, rd_ch_i} < (CH_W + 1)'(RES_CH));
    accept_s     = (state_r == STREAM) && rd_valid_r && rd_ready_i;
  end

  // Next-state for result slots, read FSM, registered read outputs and error flag
  always_comb begin
    res_n   = res_r;
    full_n  = full_r;
    state_n = state_r;
    ch_n    = ch_r;
    idx_n   = idx_r;
    if (wr_en_s) begin
      res_n[int'(wr_ch_s)*SLOT_W +: SLOT_W] = res_data_i;
      full_n[wr_ch_s]                       = 1'b1;
    end else begin
      res_n = res_r;
    end
    case (state_r)
      IDLE: begin
        if (rd_start_i && rd_ch_ok_s) begin
          state_n = STREAM;
          ch_n    = rd_ch_i;
          idx_n   = {IDX_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        if (accept_s && (idx_r == LAST_IDX)) begin
          state_n        = IDLE;
          idx_n          = {IDX_W{1'b0}};
          full_n[ch_r]   = 1'b0;
        end else if (accept_s) begin
          idx_n = idx_r + IDX_W'(1);
        end else begin
          state_n = STREAM;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = {IDX_W{1'b0}};
      end
    endcase
    // Data is taken from the post-write slot image so a stream starting alongside a write sees the new data
    rd_valid_n = (state_n == STREAM);
    rd_last_n  = rd_valid_n && (idx_n == LAST_IDX);
    rd_data_n  = rd_valid_n ? res_n[(int'(ch_n)*RES_ELEMS + int'(idx_n))*DATA_W +: DATA_W]
                            : {DATA_W{1'b0}};
    err_n      = err_r | (pop_s > 8'd1) | stream_hit_s |
                 ((state_r == IDLE) && rd_start_i && !rd_ch_ok_s);
  end

  // State and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ch_r       <= {CH_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      a_r        <= {A_W{1'b0}};
      b_r        <= {B_W{1'b0}};
      done_r     <= 1'b0;
      res_r      <= {RES_W{1'b0}};
      full_r     <= {RES_CH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      ch_r       <= ch_n;
      idx_r      <= idx_n;
      done_r     <= run_valid_i;
      if (run_valid_i) begin
        a_r <= a_flat_i;
        b_r <= b_flat_i;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
      res_r      <= res_n;
      full_r     <= full_n;
      rd_valid_r <= rd_valid_n;
      rd_last_r  <= rd_last_n;
      rd_data_r  <= rd_data_n;
      err_r      <= err_n;
    end
  end

`ifdef OPRESBUF_DROP_CNT_EN
  logic [7:0] drops_s;
  logic [8:0] drop_sum_s;
  logic [7:0] drop_cnt_r;

  // Saturating count of dropped writes: every strobe that did not load a slot
  always_comb begin
    drops_s    = pop_s - (wr_en_s ? 8'd1 : 8'd0);
    drop_sum_s = {1'b0, drop_cnt_r} + {1'b0, drops_s};
  end

  // Drop counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

  assign done_capture = done_r;
  assign a_flat_o     = a_r;
  assign b_flat_o     = b_r;
  assign res_flat_o   = res_r;
  assign res_full_o   = full_r;
  assign rd_valid_o   = rd_valid_r;
  assign rd_last_o    = rd_last_r;
  assign rd_data_o    = rd_data_r;
  assign rd_busy_o    = (state_r == STREAM);
  assign err_o        = err_r;

endmodule
